// File: rtl/mux_serializer.sv
// Parallel-in / serial-out stage: captures a W-bit word plus invert flag and emits it
// LSB-first, with bit select, inversion and output gating built only from 2:1 muxes.

module mux2 (
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic y
);
    assign y = sel ? d1 : d0;
endmodule

module mux_serializer #(
    parameter int W     = 8,
    parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_data,
    input  logic         up_invert,
    output logic         down_valid,
    input  logic         down_ready,
    output logic         down_bit,
    output logic         down_last,
    output logic         busy
);
    localparam int               N    = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(W - 1);

    typedef enum logic {IDLE, SEND} state_t;

    typedef struct packed {
        logic [W-1:0] data;
        logic         inv;
    } word_t;

    state_t           state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    word_t            word, word_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            word  <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            word  <= word_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        word_n  = word;
        case (state)
            IDLE: begin
                if (up_valid && up_ready) begin
                    word_n.data = up_data;
                    word_n.inv  = up_invert;
                    idx_n       = '0;
                    state_n     = SEND;
                end
            end
            SEND: begin
                if (down_ready) begin
                    if (idx == LAST) begin
                        idx_n   = '0;
                        state_n = IDLE;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // rst is the only input allowed to reach an output combinationally.
    assign up_ready   = (state == IDLE) && !rst;
    assign down_valid = (state == SEND);
    assign busy       = (state == SEND);
    assign down_last  = down_valid && (idx == LAST);

    // Heap-ordered select tree: node k sits at depth clog2(k+1)-1 and is steered by
    // the idx bit of matching weight (root uses the MSB). Leaves past W read as 0.
    logic [2*N-1:1] node;

    for (genvar i = 0; i < N; i++) begin : g_leaf
        if (i < W) begin : g_data
            assign node[N+i] = word.data[i];
        end else begin : g_pad
            assign node[N+i] = 1'b0;
        end
    end

    for (genvar k = 1; k < N; k++) begin : g_node
        localparam int D = $clog2(k + 1) - 1;
        mux2 u_mux (
            .d0 (node[2*k]),
            .d1 (node[2*k+1]),
            .sel(idx[IDX_W-1-D]),
            .y  (node[k])
        );
    end

    logic sel_bit, inv_bit, pol_bit;
    assign sel_bit = node[1];

    mux2 u_not  (.d0(1'b1),    .d1(1'b0),    .sel(sel_bit),    .y(inv_bit));
    mux2 u_pol  (.d0(sel_bit), .d1(inv_bit), .sel(word.inv),   .y(pol_bit));
    mux2 u_gate (.d0(1'b0),    .d1(pol_bit), .sel(down_valid), .y(down_bit));

endmodule

// File: tb/tb_mux_serializer.sv
// Randomized self-checking bench for mux_serializer (W=8 and W=1 instances).

module tb_mux_serializer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       up_valid = 1'b0, up_ready, up_invert = 1'b0;
    logic [7:0] up_data = '0;
    logic       down_valid, down_ready = 1'b0, down_bit, down_last, busy;

    logic       s_up_valid = 1'b0, s_up_ready, s_up_invert = 1'b0;
    logic [0:0] s_up_data = '0;
    logic       s_down_valid, s_down_ready = 1'b0, s_down_bit, s_down_last, s_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_serializer #(.W(8)) dut8 (
        .clk(clk), .rst(rst),
        .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data), .up_invert(up_invert),
        .down_valid(down_valid), .down_ready(down_ready), .down_bit(down_bit),
        .down_last(down_last), .busy(busy)
    );

    mux_serializer #(.W(1)) dut1 (
        .clk(clk), .rst(rst),
        .up_valid(s_up_valid), .up_ready(s_up_ready), .up_data(s_up_data), .up_invert(s_up_invert),
        .down_valid(s_down_valid), .down_ready(s_down_ready), .down_bit(s_down_bit),
        .down_last(s_down_last), .busy(s_busy)
    );

    // Drives one word into dut8 and collects what the consumer accepts.
    // mode 0: always ready, 1: ready pattern 1,0,0,..., 2: random ready.
    task automatic run8(input logic [7:0] d, input logic inv, input int mode,
                        output logic [7:0] bits, output logic [7:0] lasts, output int nbits,
                        output int unstable, output int timeouts, output logic first_ok);
        int   cyc;
        logic rdy, pv_stall, pbit, plast, done;
        bits = '0; lasts = '0; nbits = 0; unstable = 0; timeouts = 0; first_ok = 1'b0;
        pv_stall = 1'b0; pbit = 1'b0; plast = 1'b0; done = 1'b0;
        up_data = d; up_invert = inv; up_valid = 1'b1;
        cyc = 0;
        while (!up_ready && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        if (!up_ready) timeouts++;
        @(posedge clk); #1;
        up_valid  = 1'b0;
        up_data   = 8'($urandom);
        up_invert = 1'($urandom);
        first_ok  = down_valid;
        cyc = 0;
        while (!done && cyc < 200) begin
            if (pv_stall && (down_bit !== pbit || down_last !== plast)) unstable++;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            down_ready = rdy;
            if (down_valid && rdy) begin
                if (nbits < 8) begin
                    bits[nbits]  = down_bit;
                    lasts[nbits] = down_last;
                end
                nbits++;
                if (down_last) done = 1'b1;
            end
            pv_stall = down_valid && !rdy;
            pbit = down_bit; plast = down_last;
            @(posedge clk); #1; cyc++;
        end
        down_ready = 1'b0;
        if (!done) timeouts++;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (up_ready !== 1'b0 || s_up_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready_gated: got %b/%b want 0/0", up_ready, s_up_ready);
        end
        checks++; if ({down_valid, down_bit, down_last, busy} !== 4'b0) begin
            errors++; $display("FAIL reset_outputs: got v%b b%b l%b busy%b want all 0",
                               down_valid, down_bit, down_last, busy);
        end
        rst = 1'b0;
        #1;
        checks++; if (up_ready !== 1'b1 || s_up_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: got %b/%b want 1/1", up_ready, s_up_ready);
        end
        checks++; if ({s_down_valid, s_down_bit, s_down_last, s_busy} !== 4'b0) begin
            errors++; $display("FAIL reset_outputs_w1: got %b want 0000",
                               {s_down_valid, s_down_bit, s_down_last, s_busy});
        end
        @(posedge clk); #1;
    endtask

    // Checks one word's transfer against the reference: bit i = data[i] ^ inv, last only on bit W-1.
    task automatic test_word(input string name, input logic [7:0] d, input logic inv, input int mode);
        logic [7:0] bits, lasts, exp;
        int         nbits, unstable, timeouts;
        logic       first_ok;
        exp = inv ? ~d : d;
        run8(d, inv, mode, bits, lasts, nbits, unstable, timeouts, first_ok);
        checks++; if (timeouts !== 0) begin
            errors++; $display("FAIL %s_timeout: got %0d want 0", name, timeouts);
        end
        checks++; if (first_ok !== 1'b1) begin
            errors++; $display("FAIL %s_first_bit_latency: down_valid %b want 1", name, first_ok);
        end
        checks++; if (nbits !== 8) begin
            errors++; $display("FAIL %s_bit_count: got %0d want 8", name, nbits);
        end
        checks++; if (bits !== exp) begin
            errors++; $display("FAIL %s_bits: got %b want %b (lsb first from right)", name, bits, exp);
        end
        checks++; if (lasts !== 8'h80) begin
            errors++; $display("FAIL %s_last: got %b want 10000000", name, lasts);
        end
        checks++; if (unstable !== 0) begin
            errors++; $display("FAIL %s_stall_stable: got %0d changes want 0", name, unstable);
        end
        checks++; if (up_ready !== 1'b1 || down_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL %s_idle_after: got rdy%b v%b busy%b want 1 0 0",
                               name, up_ready, down_valid, busy);
        end
    endtask

    task automatic test_basic;
        test_word("basic_a5", 8'hA5, 1'b0, 0);
    endtask

    task automatic test_invert;
        test_word("invert_a5", 8'hA5, 1'b1, 0);
        test_word("invert_zero", 8'h00, 1'b1, 0);
    endtask

    task automatic test_stall;
        test_word("stall_3c", 8'h3C, 1'b0, 1);
    endtask

    task automatic test_abort;
        int   cyc, ones;
        logic seen_last;
        up_data = 8'hFF; up_invert = 1'b0; up_valid = 1'b1; down_ready = 1'b1;
        cyc = 0;
        while (!up_ready && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        @(posedge clk); #1;
        up_valid = 1'b0;
        seen_last = 1'b0; ones = 0;
        for (int i = 0; i < 3; i++) begin
            if (down_last) seen_last = 1'b1;
            if (down_valid && down_bit) ones++;
            @(posedge clk); #1;
        end
        if (down_last) seen_last = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; down_ready = 1'b0;
        #1;
        checks++; if (ones !== 3) begin
            errors++; $display("FAIL abort_pre_bits: got %0d ones want 3", ones);
        end
        checks++; if (seen_last !== 1'b0 || down_last !== 1'b0) begin
            errors++; $display("FAIL abort_no_last: got seen%b now%b want 0 0", seen_last, down_last);
        end
        checks++; if (down_valid !== 1'b0 || busy !== 1'b0 || up_ready !== 1'b1) begin
            errors++; $display("FAIL abort_idle: got v%b busy%b rdy%b want 0 0 1",
                               down_valid, busy, up_ready);
        end
        @(posedge clk); #1;
        test_word("abort_follow_01", 8'h01, 1'b0, 0);
    endtask

    task automatic test_w1;
        int cyc;
        s_up_data = 1'b1; s_up_invert = 1'b1; s_up_valid = 1'b1; s_down_ready = 1'b1;
        cyc = 0;
        while (!s_up_ready && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        @(posedge clk); #1;
        s_up_valid = 1'b0;
        checks++; if ({s_down_valid, s_down_bit, s_down_last, s_busy} !== 4'b1011) begin
            errors++; $display("FAIL w1_bit: got v/b/l/busy %b want 1011",
                               {s_down_valid, s_down_bit, s_down_last, s_busy});
        end
        @(posedge clk); #1;
        s_down_ready = 1'b0;
        checks++; if (s_down_valid !== 1'b0 || s_up_ready !== 1'b1 || s_down_last !== 1'b0) begin
            errors++; $display("FAIL w1_idle: got v%b rdy%b l%b want 0 1 0",
                               s_down_valid, s_up_ready, s_down_last);
        end
    endtask

    // up_valid held high: every other cycle is the mandatory IDLE that accepts the next word.
    task automatic test_back_to_back;
        logic d, inv, exp;
        exp = 1'b0;
        s_up_valid = 1'b1; s_down_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c % 2 == 0) begin
                checks++; if (s_up_ready !== 1'b1 || s_down_valid !== 1'b0) begin
                    errors++; $display("FAIL b2b_idle_c%0d: got rdy%b v%b want 1 0", c, s_up_ready, s_down_valid);
                end
                d = 1'($urandom); inv = 1'($urandom);
                s_up_data = d; s_up_invert = inv; exp = d ^ inv;
            end else begin
                checks++; if (s_down_valid !== 1'b1 || s_down_bit !== exp || s_down_last !== 1'b1) begin
                    errors++; $display("FAIL b2b_send_c%0d: got v%b b%b l%b want 1 %b 1",
                                       c, s_down_valid, s_down_bit, s_down_last, exp);
                end
                s_up_data = 1'($urandom); s_up_invert = 1'($urandom);
            end
            @(posedge clk); #1;
        end
        s_up_valid = 1'b0; s_down_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        for (int n = 0; n < 16; n++)
            test_word($sformatf("rand%0d", n), 8'($urandom), 1'($urandom), 2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_invert();
        test_stall();
        test_abort();
        test_w1();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
